// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder: deglitches a multiplexed 4-digit seven-segment bus and reassembles the displayed 16-bit value
module seg7_scan_decoder #(
  parameter int STABLE_CYCLES = 2,
  parameter bit SEG_ACTIVE_LOW = 1'b0,
  parameter bit DIGIT_ACTIVE_LOW = 1'b0
) (
  input  logic        ledclk,
  input  logic        rst,
  input  logic [6:0]  abcdefg,
  input  logic [3:0]  digit,
  output logic [15:0] value,
  output logic        value_valid,
  output logic        changed,
  output logic        seg_error
);
  localparam logic [3:0] S = 4'(STABLE_CYCLES);
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
    7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
  };
  logic [6:0]  seg, prev_seg;
  logic [3:0]  dig, prev_dig, cnt, cnt_n, nib, acc_nib, seen, seen_n;
  logic [1:0]  k, acc_k;
  logic        same, acc, hit, legal, acc_ok, acc_err, done;
  logic [15:0] shadow, shadow_n;
  always_comb begin
    seg = SEG_ACTIVE_LOW ? ~abcdefg : abcdefg;
    dig = DIGIT_ACTIVE_LOW ? ~digit : digit;
    same = cnt != 4'd0 && dig == prev_dig && seg == prev_seg;
    cnt_n = dig == 4'd0 ? 4'd0 : !same ? 4'd1 : cnt == S ? S : cnt + 4'd1;
    acc = cnt_n == S && !(same && cnt == S);
    hit = 1'b0;
    nib = 4'd0;
    for (int i = 0; i < 16; i++)
      if (SEG_TABLE[i] == seg) begin
        hit = 1'b1;
        nib = 4'(i);
      end
    legal = $onehot(dig) && hit;
    k = dig[1] ? 2'd1 : dig[2] ? 2'd2 : dig[3] ? 2'd3 : 2'd0;
    shadow_n = shadow;
    shadow_n[{acc_k, 2'b00} +: 4] = acc_nib;
    seen_n = seen | (4'b0001 << acc_k);
    done = acc_ok && seen_n == 4'hF;
  end
  always_ff @(posedge ledclk) begin
    if (rst) begin
      prev_dig <= 4'd0;
      prev_seg <= 7'd0;
      cnt <= 4'd0;
      acc_ok <= 1'b0;
      acc_err <= 1'b0;
      acc_k <= 2'd0;
      acc_nib <= 4'd0;
      shadow <= 16'd0;
      seen <= 4'd0;
      value <= 16'd0;
      value_valid <= 1'b0;
      changed <= 1'b0;
      seg_error <= 1'b0;
    end else begin
      prev_dig <= dig;
      prev_seg <= seg;
      cnt <= cnt_n;
      acc_ok <= acc && legal;
      acc_err <= acc && !legal;
      acc_k <= k;
      acc_nib <= nib;
      value_valid <= done;
      changed <= done && shadow_n != value;
      seg_error <= acc_err;
      if (acc_ok) shadow <= shadow_n;
      seen <= acc_err || done ? 4'd0 : acc_ok ? seen_n : seen;
      if (done) value <= shadow_n;
    end
  end
endmodule

// File: doc/seg7_scan_decoder.md
# seg7_scan_decoder

Receive-side monitor for the multiplexed 4-digit seven-segment display bus. Samples `abcdefg`/`digit` on the display clock and deglitches each digit slot. Decodes segment patterns back to hex nibbles and reassembles a complete 16-bit display value once all four digits have been seen in a scan. Used in benches and on-chip self-check to confirm that the counter's display output matches the count it drives.

## Interface
- `STABLE_CYCLES`, default 2: consecutive identical samples required before a digit slot is accepted; legal range 1..15.
- `SEG_ACTIVE_LOW`, default 0: 1 = segment lines active-low; inputs are inverted before decoding.
- `DIGIT_ACTIVE_LOW`, default 0: 1 = digit selects active-low; inputs are inverted before decoding.

Ports:
- `ledclk` in 1: display clock; the only clock.
- `rst` in 1: synchronous, active-high reset.
- `abcdefg` in 7: segment lines, bit 6 = a … bit 0 = g.
- `digit` in 4: one-hot digit select; bit k selects nibble k (bit 0 = least significant).
- `value` out 16: last complete decoded frame; nibble k = digit k.
- `value_valid` out 1: one-cycle pulse when `value` is updated.
- `changed` out 1: one-cycle pulse, coincident with `value_valid`, when the new value differs from the previous one.
- `seg_error` out 1: one-cycle pulse on an illegal select or an undecodable pattern.

## Operation
- **Normalize:** apply the polarity parameters first. All rules below use active-high levels.
- **Blank sample** (`digit`==0): ignored. Resets the stability run. No error.
- **Stability counter:** counts consecutive edges with an identical (`digit`,`abcdefg`) pair.
  - Any change restarts the run at 1.
  - The counter saturates at STABLE_CYCLES.
- **Acceptance:** one accept event per run, on the edge where the run length reaches STABLE_CYCLES. No further accepts until the pair changes.
- **Illegal select:** on an accept with more than one `digit` bit set, pulse `seg_error`, clear the `seen` mask, and store nothing.
- **Segment decode** (hex -> abcdefg): 0=7E, 1=30, 2=6D, 3=79, 4=33, 5=5B, 6=5F, 7=70, 8=7F, 9=7B, A=77, b=1F, C=4E, d=3D, E=4F, F=47.
  - Any other pattern, including 00, pulses `seg_error` and clears `seen`.
- **Valid accept of slot k:** `shadow[k]` <= nibble and `seen[k]` <= 1.
  - Re-accepting a slot already seen overwrites it silently.
- **Frame completion:** when an accept makes `seen`==4'hF:
  - `value` <= shadow, including the nibble just accepted.
  - Pulse `value_valid`.
  - Pulse `changed` if the new `value` differs from the old one.
  - Clear `seen`.
- **Shadow on error:** shadow contents survive errors; only `seen` is cleared.
- **Scan order:** arbitrary. No ordering is required.

## Timing
- **Reset values:** `value`=16'h0000, `value_valid`=0, `changed`=0, `seg_error`=0, `seen`=0, stability counter=0, shadow=0.
- **Reset mid-frame:** discards partial frame state.
- **Input sampling:** inputs are sampled at every rising `ledclk` edge.
- **Accept edge:** a pair first sampled at edge t and held is accepted at edge t+STABLE_CYCLES−1.
- **Output edge:** `value`, `value_valid`, `changed` and `seg_error` are registered and update at edge t+STABLE_CYCLES.
- **STABLE_CYCLES=1:** accepts on the first sample, at one accept per run.
- **Minimum scan:** back-to-back accepts on consecutive runs are supported. With STABLE_CYCLES=S, a full frame needs at least 4·S edges.
- **Mutual exclusion:** `seg_error` and `value_valid` never assert in the same cycle, because an error accept cannot complete a frame.
- **Reset priority:** `rst` asserted on the same edge as an accept wins; the accept is dropped.
- **Frame overlap:** a new frame may begin on the edge after completion, and the first accept of the next frame may occur on that edge.

## Test plan
- **Basic frame:** after `rst`, present digit 1..4 on `digit`=0001/0010/0100/1000 with patterns 30/6D/79/33, each held 4 cycles (S=2) -> `value`=16'h4321, `value_valid` and `changed` each high 1 cycle, 2 edges after digit 3's first sample.
- **Repeat frame:** repeat the identical scan -> `value_valid` pulses, `changed`=0, `value` stays 16'h4321.
- **Glitch rejection:** with S=2, a 1-cycle slot (`digit`=0001, 7F) inserted between slots -> no accept; `value` nibble 0 unchanged after the next frame unless it is properly held.
- **Illegal select:** `digit`=0011 held 3 cycles -> single `seg_error` pulse and `seen` cleared; the next 3 valid slots do not complete a frame; a full 4-slot scan then yields `value_valid`.
- **Bad pattern and blanking:** pattern 01 on slot 2 -> `seg_error` pulse; blank cycles (`digit`=0) between slots -> no error and no effect on the frame.
- **Reset mid-frame:** `rst` for 1 cycle after 2 slots are accepted -> outputs return to reset values; the remaining 2 slots alone do not produce `value_valid`.
